store_unit: RTL and testbench

Store-side memory interface for the Morty RV32 core. It takes SB/SH/SW requests from the execute stage and generates word-aligned address, byte selects and lane-replicated write data. It runs one Wishbone-style write cycle to data memory and reports completion or exception back to the pipeline. It is the write-side counterpart of the load unit.

---
 rtl/store_unit_pkg.sv | 18 +
 rtl/store_align.sv | 39 +++
 rtl/store_unit.sv | 120 ++++++++++++
 tb/tb_store_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/store_unit_pkg.sv
// Shared constants for the store unit: funct3 encodings, exception codes, FSM states.
package store_unit_pkg;

  // Store funct3 encodings, matching the load unit's LB/LH/LW values
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [1:0] EXC_OK       = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUS      = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/store_align.sv
// Combinational store lane steering: byte selects, replicated write data,
// and misalignment / illegal-funct3 detection.
module store_align
  import store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  sel,
  output logic [31:0] dat,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    sel        = 4'b0000;
    dat        = 32'h0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_SB: begin
        sel = 4'b0001 << addr_lo;
        dat = {4{data[7:0]}};
      end
      F3_SH: begin
        sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
        dat        = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      F3_SW: begin
        sel        = 4'b1111;
        dat        = data;
        misaligned = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: one Wishbone write per SB/SH/SW request, reports done/exception.
// Optional bus timeout enabled by defining STORE_UNIT_TIMEOUT_EN.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  output logic        done_o,
  output logic [1:0]  exc_code_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  logic [1:0]  state_reg;
  logic [31:0] adr_reg;
  logic [31:0] dat_reg;
  logic [3:0]  sel_reg;
  logic [1:0]  exc_reg;

  logic [3:0]  align_sel;
  logic [31:0] align_dat;
  logic        align_misaligned;
  logic        align_illegal;

  store_align u_align (
    .funct3     (funct3_i),
    .addr_lo    (addr_i[1:0]),
    .data       (data_i),
    .sel        (align_sel),
    .dat        (align_dat),
    .misaligned (align_misaligned),
    .illegal    (align_illegal)
  );

`ifdef STORE_UNIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] timeout_cnt_reg;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      adr_reg   <= 32'h0;
      dat_reg   <= 32'h0;
      sel_reg   <= 4'b0000;
      exc_reg   <= EXC_OK;
`ifdef STORE_UNIT_TIMEOUT_EN
      timeout_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i) begin
            // Faulting requests skip the bus and leave the bus registers untouched
            if (align_illegal) begin
              exc_reg   <= EXC_ILLEGAL;
              state_reg <= ST_RESP;
            end else if (align_misaligned) begin
              exc_reg   <= EXC_MISALIGN;
              state_reg <= ST_RESP;
            end else begin
              adr_reg   <= {addr_i[31:2], 2'b00};
              sel_reg   <= align_sel;
              dat_reg   <= align_dat;
              state_reg <= ST_BUS;
`ifdef STORE_UNIT_TIMEOUT_EN
              timeout_cnt_reg <= '0;
`endif
            end
          end
        end
        ST_BUS: begin
          if (wb_err_i) begin
            exc_reg   <= EXC_BUS;
            state_reg <= ST_RESP;
          end else if (wb_ack_i) begin
            exc_reg   <= EXC_OK;
            state_reg <= ST_RESP;
          end
`ifdef STORE_UNIT_TIMEOUT_EN
          else if (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            exc_reg   <= EXC_BUS;
            state_reg <= ST_RESP;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
`endif
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_reg == ST_IDLE);
  assign done_o      = (state_reg == ST_RESP);
  assign exc_code_o  = exc_reg;
  assign wb_cyc_o    = (state_reg == ST_BUS);
  assign wb_stb_o    = wb_cyc_o;
  assign wb_we_o     = wb_cyc_o;
  assign wb_adr_o    = adr_reg;
  assign wb_dat_o    = dat_reg;
  assign wb_sel_o    = sel_reg;

endmodule

// File: tb/tb_store_unit.sv
// Randomized bench for store_unit against a lane/size reference model.
module tb_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] data;
  logic [2:0]  funct3;
  logic        done;
  logic [1:0]  exc_code;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_ack;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .addr_i      (addr),
    .data_i      (data),
    .funct3_i    (funct3),
    .done_o      (done),
    .exc_code_o  (exc_code),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_dat),
    .wb_sel_o    (wb_sel),
    .wb_we_o     (wb_we),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_ack_i    (wb_ack),
    .wb_err_i    (wb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Access size in bytes; 0 means the funct3 is not a store
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_sel(input int n, input logic [31:0] a);
    int v;
    v = ((1 << n) - 1) << (a % 4);
    return v[3:0];
  endfunction

  // Byte lane i carries source byte (i mod size)
  function automatic logic [31:0] model_dat(input int n, input logic [31:0] d);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 4; i++)
      r = r | (((d >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  // kind: 0 = no response, 1 = ack, 2 = err, 3 = ack and err together
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                          input int waits, input int kind);
    int n, exp_exc, exp_cyc, exp_done, cyc_cnt, done_at;
    logic [1:0] got_exc;
    logic bad;
    n   = size_of(f3);
    bad = (n == 0) || ((a % n) != 0);
    if (n == 0) exp_exc = 3;
    else if ((a % n) != 0) exp_exc = 1;
    else if (kind == 1) exp_exc = 0;
    else exp_exc = 2;
    exp_cyc  = bad ? 0 : ((kind == 0) ? TO : waits + 1);
    exp_done = bad ? 1 : exp_cyc + 1;

    req_valid = 1'b1; addr = a; data = d; funct3 = f3;
    check("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc_cnt = 0; done_at = 0; got_exc = 2'b00;
    for (int c = 1; c <= 60 && done_at == 0; c++) begin
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0;
      if (done) begin
        done_at = c;
        got_exc = exc_code;
        check("cyc_low_at_done", 32'(wb_cyc), 32'd0);
      end else if (wb_cyc) begin
        cyc_cnt++;
        if (cyc_cnt == 1) begin
          check("wb_adr", wb_adr, a & 32'hFFFF_FFFC);
          check("wb_sel", 32'(wb_sel), 32'(model_sel(n, a)));
          check("wb_dat", wb_dat, model_dat(n, d));
          check("wb_we_stb", {30'd0, wb_we, wb_stb}, 32'd3);
        end
        if (kind != 0 && cyc_cnt == waits + 1) begin
          wb_ack = (kind == 1 || kind == 3);
          wb_err = (kind >= 2);
        end
      end
    end
    check("done_latency", 32'(done_at), 32'(exp_done));
    check("cyc_cycles", 32'(cyc_cnt), 32'(exp_cyc));
    check("exc_code", 32'(got_exc), 32'(exp_exc));
    $display("store f3=%0d addr=%08h data=%08h waits=%0d kind=%0d -> exc=%0d done_at=%0d cyc=%0d",
             f3, a, d, waits, kind, got_exc, done_at, cyc_cnt);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_after_done", 32'(req_ready), 32'd1);
    check("exc_hold", 32'(exc_code), 32'(exp_exc));
  endtask

  initial begin
    logic [2:0] f3;
    rst = 1'b1; req_valid = 1'b0; addr = 0; data = 0; funct3 = 0;
    wb_ack = 1'b0; wb_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", {29'd0, wb_cyc, wb_stb, wb_we}, 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat", wb_dat, 32'd0);
    check("rst_sel", 32'(wb_sel), 32'd0);
    check("rst_done_exc", {29'd0, done, exc_code}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);

    do_store(32'h0000_1003, 32'hAABB_CCDD, 3'b000, 0, 1);
    do_store(32'h0000_2002, 32'h1234_5678, 3'b001, 3, 1);
    do_store(32'h0000_3001, 32'hDEAD_BEEF, 3'b010, 0, 1);
    do_store(32'h0000_3001, 32'hDEAD_BEEF, 3'b100, 0, 1);
    do_store(32'h0000_4000, 32'hCAFE_F00D, 3'b010, 2, 3);
    do_store(32'h0000_4004, 32'h0BAD_CAFE, 3'b010, 1, 1);

    // Reset while a bus cycle is outstanding
    req_valid = 1'b1; addr = 32'h0000_5000; data = 32'h1111_2222; funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("midbus_cyc_high", 32'(wb_cyc), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midbus_cyc_drop", {30'd0, wb_cyc, wb_stb}, 32'd0);
    check("midbus_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", {30'd0, done, req_ready}, 32'd1);
    end
    $display("reset during bus cycle handled");

`ifdef STORE_UNIT_TIMEOUT_EN
    do_store(32'h0000_6000, 32'h5555_AAAA, 3'b010, 0, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      do_store($urandom, $urandom, f3, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
